// File: rtl/exc_arbiter.sv
// MEM-stage exception arbiter: picks one exception code per instruction, drives CP0 and
// the pipeline flush/redirect, then holds a flush shadow. Optional counters: EXC_ARBITER_STATS_EN.
module exc_arbiter #(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] EXC_OFFSET   = 32'h00000180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        inst_valid_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [31:0] cp0_ebase_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] epc_o
`ifdef EXC_ARBITER_STATS_EN
    ,
    output logic [31:0] exc_count_o,
    output logic [31:0] eret_count_o
`endif
);

    localparam logic [4:0] CODE_NONE  = 5'h00;
    localparam logic [4:0] CODE_INT   = 5'h01;
    localparam logic [4:0] CODE_SYS   = 5'h08;
    localparam logic [4:0] CODE_RI    = 5'h0a;
    localparam logic [4:0] CODE_OV    = 5'h0c;
    localparam logic [4:0] CODE_TRAP  = 5'h0d;
    localparam logic [4:0] CODE_ERET  = 5'h0e;
    localparam logic [4:0] CODE_BREAK = 5'h0f;
    localparam logic [4:0] CODE_ADEL  = 5'h10;
    localparam logic [4:0] CODE_ADELD = 5'h11;
    localparam logic [4:0] CODE_ADES  = 5'h12;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SHADOW
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    logic [31:0] status_f;
    logic [31:0] cause_f;
    logic [31:0] epc_f;
    logic        int_pend;
    logic [4:0]  code;
    logic        take;
    logic [31:0] handler_pc;
    logic        unused_bits;

    // A WB-stage mtc0 has not reached CP0 yet, so its value must override the stale register.
    always_comb begin
        status_f = cp0_status_i;
        cause_f  = cp0_cause_i;
        epc_f    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                REG_STATUS: status_f = wb_cp0_data_i;
                REG_CAUSE: begin
                    cause_f[9:8]   = wb_cp0_data_i[9:8];
                    cause_f[23:22] = wb_cp0_data_i[23:22];
                end
                REG_EPC:   epc_f = wb_cp0_data_i;
                default: ;
            endcase
        end
    end

    assign int_pend = ((cause_f[15:8] & status_f[15:8]) != 8'h00)
                      && status_f[0] && !status_f[1];

    assign unused_bits = ^{status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0]};

    always_comb begin
        code = CODE_NONE;
        if (int_pend)             code = CODE_INT;
        else if (exc_flags_i[0])  code = CODE_ADEL;
        else if (exc_flags_i[1])  code = CODE_SYS;
        else if (exc_flags_i[2])  code = CODE_RI;
        else if (exc_flags_i[3])  code = CODE_BREAK;
        else if (exc_flags_i[4])  code = CODE_TRAP;
        else if (exc_flags_i[5])  code = CODE_OV;
        else if (exc_flags_i[6])  code = CODE_ADELD;
        else if (exc_flags_i[7])  code = CODE_ADES;
        else if (exc_flags_i[8])  code = CODE_ERET;
    end

    // Gating with rst keeps every exception output quiet during the reset cycle.
    assign take = !rst && (state == IDLE) && inst_valid_i && !stall_i
                  && (code != CODE_NONE);

    assign handler_pc = (cp0_ebase_i & 32'hFFFF_F000) + EXC_OFFSET;

    always_comb begin
        excepttype_o = 32'h0;
        flush_o      = 1'b0;
        new_pc_o     = 32'h0;
        badvaddr_o   = 32'h0;
        if (take) begin
            excepttype_o = {27'h0, code};
            flush_o      = 1'b1;
            new_pc_o     = (code == CODE_ERET) ? epc_f : handler_pc;
            if (code == CODE_ADEL)
                badvaddr_o = inst_addr_i;
            else if ((code == CODE_ADELD) || (code == CODE_ADES))
                badvaddr_o = mem_addr_i;
        end
    end

    assign current_inst_addr_o = inst_addr_i;
    assign is_in_delayslot_o   = in_delayslot_i;
    assign epc_o               = epc_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The shadow counts down regardless of stall so the drain window has a fixed length.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next = SHADOW;
                    cnt_next   = CNT_INIT;
                end
            end
            SHADOW: begin
                if (cnt == 4'd0)
                    state_next = IDLE;
                else
                    cnt_next = cnt - 4'd1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

`ifdef EXC_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count_o  <= 32'h0;
            eret_count_o <= 32'h0;
        end else if (take) begin
            if (code == CODE_ERET)
                eret_count_o <= eret_count_o + 32'h1;
            else
                exc_count_o <= exc_count_o + 32'h1;
        end
    end
`endif

endmodule
